// File: rtl/stream_deframer.sv
// stream_deframer: byte-stream deframer between the receive-side skid buffer
// and the pixel unpacker. Each frame is packet_len_bytes_p payload bytes
// followed by a two-byte tail (tail_byte_0_p, tail_byte_1_p). Payload bytes
// pass through a one-stage registered handshake, and last_o marks the final
// payload byte. Tail bytes are stripped. After a bad tail, bytes are dropped
// until the next valid tail so that downstream image geometry stays aligned.
// Optional feature macro: STREAM_DEFRAMER_TIMEOUT_EN adds an idle timeout
// that abandons a partial frame and starts hunting for the next tail.
module stream_deframer #(
  parameter int unsigned         width_p            = 8,
  parameter int unsigned         packet_len_bytes_p = 9600,
  parameter logic [width_p-1:0]  tail_byte_0_p      = width_p'(8'h0D),
  parameter logic [width_p-1:0]  tail_byte_1_p      = width_p'(8'h0A),
  parameter int unsigned         timeout_cycles_p   = 1000000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic               last_o,
  input  logic               ready_i,
  output logic               frame_done_o,
  output logic               sync_err_o,
  output logic [15:0]        frame_count_o,
  output logic [7:0]         err_count_o
);

  localparam int unsigned      CntW    = (packet_len_bytes_p > 1) ? $clog2(packet_len_bytes_p) : 1;
  localparam logic [CntW-1:0]  LastIdx = CntW'(packet_len_bytes_p - 1);

  typedef enum logic [2:0] {
    ST_PAYLOAD = 3'd0,
    ST_TAIL0   = 3'd1,
    ST_TAIL1   = 3'd2,
    ST_HUNT0   = 3'd3,
    ST_HUNT1   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CntW-1:0]    r_cnt;
  logic [CntW-1:0]    w_cnt_nxt;

  logic               r_valid;
  logic [width_p-1:0] r_data;
  logic               r_last;
  logic               r_frame_done;
  logic               r_sync_err;
  logic [15:0]        r_frame_cnt;
  logic [7:0]         r_err_cnt;

  logic               w_ready;
  logic               w_acc;
  logic               w_load;
  logic               w_last_nxt;
  logic               w_done;
  logic               w_err;
  logic               w_timeout;

  // The output register may take a new byte when empty or draining this cycle.
  assign w_ready = ~r_valid | ready_i;
  assign w_acc   = valid_i & w_ready;

`ifdef STREAM_DEFRAMER_TIMEOUT_EN
  localparam int unsigned      IdleW    = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p + 1) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(timeout_cycles_p - 1);

  logic [IdleW-1:0] r_idle;
  logic             w_idle_cond;

  // Idle time only matters once a frame is under way; fresh-frame PAYLOAD and HUNT0 wait forever.
  assign w_idle_cond = ~valid_i & (r_state != ST_HUNT0) &
                       ((r_state != ST_PAYLOAD) | (r_cnt != '0));
  assign w_timeout   = w_idle_cond & (r_idle == IdleLast);

  // Idle-cycle counter, cleared by any accepted byte or by the timeout itself.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_idle <= '0;
    end else if (w_acc | w_timeout) begin
      r_idle <= '0;
    end else if (w_idle_cond) begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (timeout_cycles_p == 0);
`endif

  // Next-state, byte counter and event decode for the framing FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_last_nxt  = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_PAYLOAD: begin
        if (w_acc) begin
          w_load = 1'b1;
          if (r_cnt == LastIdx) begin
            w_last_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_TAIL0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_TAIL0: begin
        if (w_acc) begin
          if (data_i == tail_byte_0_p) begin
            w_state_nxt = ST_TAIL1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT0;
          end
        end
      end
      ST_TAIL1: begin
        if (w_acc) begin
          if (data_i == tail_byte_1_p) begin
            w_done      = 1'b1;
            w_state_nxt = ST_PAYLOAD;
          end else begin
            w_err = 1'b1;
            // A stray first tail byte may itself start the real tail.
            w_state_nxt = (data_i == tail_byte_0_p) ? ST_HUNT1 : ST_HUNT0;
          end
        end
      end
      ST_HUNT0: begin
        if (w_acc && (data_i == tail_byte_0_p)) begin
          w_state_nxt = ST_HUNT1;
        end
      end
      ST_HUNT1: begin
        if (w_acc) begin
          if (data_i == tail_byte_1_p) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PAYLOAD;
          end else if (data_i != tail_byte_0_p) begin
            w_state_nxt = ST_HUNT0;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_PAYLOAD;
      end
    endcase
    // A timeout only fires with valid_i low, so it never collides with an accepted byte.
    if (w_timeout) begin
      w_err       = 1'b1;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_HUNT0;
    end
  end

  // FSM state and payload byte counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_PAYLOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output register: loads payload bytes only, holds while stalled, empties after transfer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
      r_last  <= w_last_nxt;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Single-cycle event pulses.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      r_sync_err   <= w_err;
    end
  end

  // Good-frame count wraps; error count saturates so it never reads as a small value again.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign ready_o       = w_ready;
  assign valid_o       = r_valid;
  assign data_o        = r_data;
  assign last_o        = r_last;
  assign frame_done_o  = r_frame_done;
  assign sync_err_o    = r_sync_err;
  assign frame_count_o = r_frame_cnt;
  assign err_count_o   = r_err_cnt;

endmodule

// File: tb/tb_stream_deframer.sv
// Scoreboard bench for stream_deframer with a 4-byte payload frame.
// Expected payload bytes are queued by the stimulus, and a monitor pops them
// as the DUT hands bytes downstream.
module tb_stream_deframer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       last_o;
  logic       ready_i = 1'b1;
  logic       frame_done_o;
  logic       sync_err_o;
  logic [15:0] frame_count_o;
  logic [7:0]  err_count_o;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;
  int n_err  = 0;
  logic tog_en = 1'b0;
  logic [8:0] sb[$];

  stream_deframer #(
    .width_p(8),
    .packet_len_bytes_p(4),
    .tail_byte_0_p(8'h0D),
    .tail_byte_1_p(8'h0A),
    .timeout_cycles_p(10)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .last_o(last_o),
    .ready_i(ready_i),
    .frame_done_o(frame_done_o),
    .sync_err_o(sync_err_o),
    .frame_count_o(frame_count_o),
    .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks stall stability.
  task automatic mon_loop();
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    logic [8:0] item;
    prev_stall = 1'b0;
    prev_d = 8'h00;
    prev_l = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {23'd0, valid_o, last_o, data_o}, {23'd0, 1'b1, prev_l, prev_d});
        end
        if (valid_o && ready_i) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output: got data 0x%0h last %0d, expected nothing", data_o, last_o);
          end else begin
            item = sb.pop_front();
            check("out_byte", {23'd0, last_o, data_o}, {23'd0, item});
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_d = data_o;
        prev_l = last_o;
        if (frame_done_o) n_done++;
        if (sync_err_o) n_err++;
      end
    end
  endtask

  // Downstream ready: steady high, or toggling every cycle when enabled.
  task automatic ready_loop();
    forever begin
      @(posedge clk_i);
      #1;
      if (tog_en) ready_i = ~ready_i;
      else ready_i = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    valid_i = 1'b1;
    data_i = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, expected acceptance within 50 cycles", b);
    end
  endtask

  task automatic pay(input logic [7:0] b, input logic l);
    sb.push_back({l, b});
    send_byte(b);
  endtask

  task automatic bus_idle();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus_idle();
    n = 0;
    while ((sb.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d bytes still pending, expected 0", sb.size());
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    bus_idle();
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_data", {24'd0, data_o}, 0);
    check("rst_last", {31'd0, last_o}, 0);
    check("rst_frame_cnt", {16'd0, frame_count_o}, 0);
    check("rst_err_cnt", {24'd0, err_count_o}, 0);
    check("rst_pulses", {30'd0, frame_done_o, sync_err_o}, 0);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic good_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    pay(a, 1'b0);
    pay(b, 1'b0);
    pay(c, 1'b0);
    pay(d, 1'b1);
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  initial begin
    int d0;
    int e0;
    fork
      mon_loop();
      ready_loop();
    join_none

    // Two clean frames, continuous ready.
    do_reset();
    d0 = n_done; e0 = n_err;
    good_frame(8'h01, 8'h02, 8'h03, 8'h04);
    good_frame(8'h01, 8'h02, 8'h03, 8'h04);
    drain();
    check("t1_frame_cnt", {16'd0, frame_count_o}, 2);
    check("t1_err_cnt", {24'd0, err_count_o}, 0);
    check("t1_done_pulses", n_done - d0, 2);
    check("t1_err_pulses", n_err - e0, 0);

    // Same stream with ready toggling.
    do_reset();
    tog_en = 1'b1;
    d0 = n_done; e0 = n_err;
    good_frame(8'h01, 8'h02, 8'h03, 8'h04);
    good_frame(8'h01, 8'h02, 8'h03, 8'h04);
    drain();
    tog_en = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("t2_frame_cnt", {16'd0, frame_count_o}, 2);
    check("t2_done_pulses", n_done - d0, 2);

    // Bad second tail byte, hunt, resync.
    do_reset();
    d0 = n_done; e0 = n_err;
    pay(8'h01, 1'b0); pay(8'h02, 1'b0); pay(8'h03, 1'b0); pay(8'h04, 1'b1);
    send_byte(8'h0D); send_byte(8'h55);
    send_byte(8'h0D); send_byte(8'h0D); send_byte(8'h0A);
    good_frame(8'h11, 8'h22, 8'h33, 8'h44);
    drain();
    check("t3_frame_cnt", {16'd0, frame_count_o}, 1);
    check("t3_err_cnt", {24'd0, err_count_o}, 1);
    check("t3_err_pulses", n_err - e0, 1);
    check("t3_done_pulses", n_done - d0, 1);

    // Payload bytes equal to the tail values.
    do_reset();
    good_frame(8'h0D, 8'h0A, 8'h0D, 8'h0A);
    drain();
    check("t4_frame_cnt", {16'd0, frame_count_o}, 1);
    check("t4_err_cnt", {24'd0, err_count_o}, 0);

    // 300 bad tails: error count saturates.
    do_reset();
    e0 = n_err;
    for (int i = 0; i < 300; i++) begin
      pay(8'(i), 1'b0); pay(8'h5A, 1'b0); pay(8'hA5, 1'b0); pay(8'hFF, 1'b1);
      send_byte(8'h00);
      send_byte(8'h0D);
      send_byte(8'h0A);
    end
    drain();
    check("t5_err_cnt_sat", {24'd0, err_count_o}, 32'hFF);
    check("t5_err_pulses", n_err - e0, 300);
    check("t5_frame_cnt", {16'd0, frame_count_o}, 0);

    // Reset after two payload bytes, then a full frame.
    do_reset();
    pay(8'h01, 1'b0); pay(8'h02, 1'b0);
    drain();
    do_reset();
    d0 = n_done;
    good_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    drain();
    check("t6_frame_cnt", {16'd0, frame_count_o}, 1);
    check("t6_done_pulses", n_done - d0, 1);
    check("t6_err_cnt", {24'd0, err_count_o}, 0);

`ifdef STREAM_DEFRAMER_TIMEOUT_EN
    // Idle timeout abandons a partial frame.
    do_reset();
    e0 = n_err; d0 = n_done;
    pay(8'h01, 1'b0); pay(8'h02, 1'b0);
    bus_idle();
    repeat (15) @(posedge clk_i);
    #1;
    check("t7_timeout_pulse", n_err - e0, 1);
    check("t7_err_cnt", {24'd0, err_count_o}, 1);
    send_byte(8'h0D); send_byte(8'h0A);
    good_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    drain();
    check("t7_frame_cnt", {16'd0, frame_count_o}, 1);
    check("t7_done_pulses", n_done - d0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
